// File: rtl/pre_if_stage.sv
// pre_if_stage: PC generation and instruction-SRAM request stage feeding IF.
// Owns the PC of the instruction in IF, drives to_fs_valid/br_taken_cancel,
// issues the 1-cycle-latency synchronous inst_sram read and buffers branch
// redirects that arrive while IF is stalled.
// Optional feature macro: PRE_IF_EXC_REDIRECT_EN adds ex_flush/ex_entry,
// a top-priority exception redirect that does not wait for IF to accept.

module pre_if_stage #(
  parameter logic [31:0] RESET_PC = 32'h1c00_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fs_allow_in,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  output logic [31:0] pc,
  output logic        to_fs_valid,
  output logic        br_taken_cancel,
  output logic        inst_sram_en,
  output logic [31:0] inst_sram_addr
`ifdef PRE_IF_EXC_REDIRECT_EN
  ,
  input  logic        ex_flush,
  input  logic [31:0] ex_entry
`endif
);

  typedef enum logic [1:0] {
    ST_BOOT    = 2'd0,
    ST_RUN     = 2'd1,
    ST_BR_PEND = 2'd2
  } state_e;

  state_e      state_r;
  state_e      state_nxt_s;
  logic [31:0] pc_r;
  logic [31:0] pc_nxt_s;
  logic [31:0] br_buf_r;
  logic [31:0] br_buf_nxt_s;
  logic [31:0] br_target_al_s;
  logic [31:0] seq_pc_s;
  logic [31:0] nextpc_s;
  logic [31:0] sram_addr_s;
  logic        in_boot_s;
  logic        in_pend_s;
  logic        valid_s;
  logic        advance_s;
  logic        ex_flush_s;
  logic [31:0] ex_entry_s;
  logic [1:0]  state_bits_s;

`ifdef PRE_IF_EXC_REDIRECT_EN
  assign ex_flush_s = ex_flush;
  assign ex_entry_s = ex_entry;
`else
  assign ex_flush_s = 1'b0;
  assign ex_entry_s = 32'h0000_0000;
`endif

  // Low two target bits are dropped; misalignment is not trapped in this stage.
  assign br_target_al_s = br_target & 32'hffff_fffc;
  assign seq_pc_s       = pc_r + PC_STEP;

  // Decode state into flags; an illegal encoding behaves like BOOT and recovers to RUN.
  always_comb begin
    in_boot_s = 1'b0;
    in_pend_s = 1'b0;
    case (state_r)
      ST_BOOT:    in_boot_s = 1'b1;
      ST_RUN:     in_pend_s = 1'b0;
      ST_BR_PEND: in_pend_s = 1'b1;
      default:    in_boot_s = 1'b1;
    endcase
  end

  assign valid_s   = !in_boot_s && !reset;
  assign advance_s = valid_s && fs_allow_in;

  // Select the next PC: exception, then live branch, then buffered branch, then sequential.
  always_comb begin
    nextpc_s = seq_pc_s;
    if (ex_flush_s) begin
      nextpc_s = ex_entry_s;
    end else if (br_taken) begin
      nextpc_s = br_target_al_s;
    end else if (in_pend_s) begin
      nextpc_s = br_buf_r;
    end else begin
      nextpc_s = seq_pc_s;
    end
  end

  // Read the next PC when the fetch moves on; otherwise re-read pc so IF sees stable data.
  always_comb begin
    sram_addr_s = pc_r;
    pc_nxt_s    = pc_r;
    if (advance_s || in_boot_s || ex_flush_s) begin
      sram_addr_s = nextpc_s;
      pc_nxt_s    = nextpc_s;
    end else begin
      sram_addr_s = pc_r;
      pc_nxt_s    = pc_r;
    end
  end

  // Next-state and redirect-buffer logic; newest unaccepted branch overwrites the buffer.
  always_comb begin
    state_nxt_s  = state_r;
    br_buf_nxt_s = br_buf_r;
    if (ex_flush_s) begin
      state_nxt_s = ST_RUN;
    end else if (br_taken && !advance_s) begin
      br_buf_nxt_s = br_target_al_s;
      state_nxt_s  = ST_BR_PEND;
    end else if (in_boot_s) begin
      state_nxt_s = ST_RUN;
    end else if (in_pend_s && advance_s) begin
      state_nxt_s = ST_RUN;
    end else begin
      state_nxt_s = state_r;
    end
  end

  // State, PC and redirect buffer registers; reset discards any buffered redirect.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r  <= ST_BOOT;
      pc_r     <= RESET_PC - PC_STEP;
      br_buf_r <= 32'h0000_0000;
    end else begin
      state_r  <= state_nxt_s;
      pc_r     <= pc_nxt_s;
      br_buf_r <= br_buf_nxt_s;
    end
  end

  assign pc              = pc_r;
  assign to_fs_valid     = valid_s;
  assign br_taken_cancel = (br_taken || ex_flush_s) && !reset;
  assign inst_sram_en    = !reset;
  assign inst_sram_addr  = sram_addr_s;

  assign state_bits_s = state_r;

  pre_if_stage_chk u_chk (
    .clk             (clk),
    .reset           (reset),
    .state_bits      (state_bits_s),
    .to_fs_valid     (to_fs_valid),
    .inst_sram_en    (inst_sram_en),
    .br_taken        (br_taken),
    .br_taken_cancel (br_taken_cancel)
  );

endmodule

// pre_if_stage_chk: invariants of the pre-IF stage, kept apart from the datapath.
module pre_if_stage_chk (
  input logic       clk,
  input logic       reset,
  input logic [1:0] state_bits,
  input logic       to_fs_valid,
  input logic       inst_sram_en,
  input logic       br_taken,
  input logic       br_taken_cancel
);

  a_sram_en: assert property (@(posedge clk) inst_sram_en == !reset);

  a_state_legal: assert property (@(posedge clk) disable iff (reset)
    state_bits != 2'd3);

  a_boot_not_valid: assert property (@(posedge clk) disable iff (reset)
    (state_bits == 2'd0) |-> !to_fs_valid);

  a_cancel: assert property (@(posedge clk) disable iff (reset)
    br_taken |-> br_taken_cancel);

endmodule

// File: tb/tb_pre_if_stage.sv
// tb_pre_if_stage: directed scenarios plus random stimulus, checked every
// cycle against a fetch-level reference model of the pre-IF stage.

module tb_pre_if_stage;

  localparam logic [31:0] RST_PC = 32'h1c00_0000;

  logic        clk;
  logic        reset;
  logic        fs_allow_in;
  logic        br_taken;
  logic [31:0] br_target;
  logic [31:0] pc;
  logic        to_fs_valid;
  logic        br_taken_cancel;
  logic        inst_sram_en;
  logic [31:0] inst_sram_addr;

  int tests_run;
  int tests_failed;

  // Reference model: where fetch stands, whether it is still booting,
  // and the redirect (if any) waiting for IF to accept.
  logic [31:0] m_pc;
  bit          m_boot;
  bit          m_pend;
  logic [31:0] m_buf;

  pre_if_stage dut (
    .clk             (clk),
    .reset           (reset),
    .fs_allow_in     (fs_allow_in),
    .br_taken        (br_taken),
    .br_target       (br_target),
    .pc              (pc),
    .to_fs_valid     (to_fs_valid),
    .br_taken_cancel (br_taken_cancel),
    .inst_sram_en    (inst_sram_en),
    .inst_sram_addr  (inst_sram_addr)
  );

  // 100 MHz free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Where fetch should go next, from the architectural redirect rules.
  function automatic logic [31:0] model_next(input bit br, input logic [31:0] tgt);
    if (br) return {tgt[31:2], 2'b00};
    if (m_pend) return m_buf;
    return m_pc + 32'd4;
  endfunction

  task automatic model_reset();
    m_pc   = RST_PC - 32'd4;
    m_boot = 1'b1;
    m_pend = 1'b0;
    m_buf  = 32'h0;
  endtask

  // One clock: apply inputs, check all outputs mid-cycle, then advance the model.
  task automatic cycle(input bit r, input bit a, input bit b, input logic [31:0] t);
    bit          exp_valid;
    bit          adv;
    logic [31:0] np;
    reset       = r;
    fs_allow_in = a;
    br_taken    = b;
    br_target   = t;
    @(negedge clk);
    exp_valid = !m_boot && !r;
    adv       = exp_valid && a;
    np        = model_next(b, t);
    check_eq("pc", pc, m_pc);
    check_eq("to_fs_valid", {31'd0, to_fs_valid}, {31'd0, exp_valid});
    check_eq("br_taken_cancel", {31'd0, br_taken_cancel}, {31'd0, (b && !r)});
    check_eq("inst_sram_en", {31'd0, inst_sram_en}, {31'd0, !r});
    check_eq("inst_sram_addr", inst_sram_addr, (adv || m_boot) ? np : m_pc);
    @(posedge clk);
    if (r) begin
      model_reset();
    end else begin
      if (adv || m_boot) m_pc = np;
      if (b && !adv) begin
        m_buf  = {t[31:2], 2'b00};
        m_pend = 1'b1;
      end else if (m_pend && adv) begin
        m_pend = 1'b0;
      end
      m_boot = 1'b0;
    end
    #1;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset        = 1'b1;
    fs_allow_in  = 1'b0;
    br_taken     = 1'b0;
    br_target    = 32'h0;
    @(posedge clk);
    model_reset();
    #1;

    // 1: reset, boot, sequential fetch
    repeat (3) cycle(1'b1, 1'b1, 1'b0, 32'h0);
    check_eq("t1_reset_pc", pc, 32'h1bff_fffc);
    cycle(1'b0, 1'b1, 1'b0, 32'h0);
    check_eq("t1_pc0", pc, 32'h1c00_0000);
    check_eq("t1_valid", {31'd0, to_fs_valid}, 32'd1);
    cycle(1'b0, 1'b1, 1'b0, 32'h0);
    check_eq("t1_pc1", pc, 32'h1c00_0004);
    cycle(1'b0, 1'b1, 1'b0, 32'h0);
    check_eq("t1_pc2", pc, 32'h1c00_0008);

    // 2: stall holds pc and re-reads it
    repeat (4) cycle(1'b0, 1'b0, 1'b0, 32'h0);
    check_eq("t2_stall_pc", pc, 32'h1c00_0008);
    check_eq("t2_stall_addr", inst_sram_addr, 32'h1c00_0008);
    cycle(1'b0, 1'b1, 1'b0, 32'h0);
    check_eq("t2_resume_pc", pc, 32'h1c00_000c);

    // 3: branch accepted immediately
    cycle(1'b0, 1'b1, 1'b1, 32'h1c00_0100);
    check_eq("t3_br_pc", pc, 32'h1c00_0100);

    // 4: branch while stalled is buffered
    cycle(1'b0, 1'b0, 1'b1, 32'h1c00_0200);
    check_eq("t4_pend_pc", pc, 32'h1c00_0100);
    cycle(1'b0, 1'b0, 1'b0, 32'h0);
    check_eq("t4_pend_pc2", pc, 32'h1c00_0100);
    cycle(1'b0, 1'b1, 1'b0, 32'h0);
    check_eq("t4_accept_pc", pc, 32'h1c00_0200);
    cycle(1'b0, 1'b1, 1'b0, 32'h0);
    check_eq("t4_run_pc", pc, 32'h1c00_0204);

    // 5: newest buffered branch wins
    cycle(1'b0, 1'b0, 1'b1, 32'h1c00_0300);
    cycle(1'b0, 1'b0, 1'b1, 32'h1c00_0400);
    cycle(1'b0, 1'b1, 1'b0, 32'h0);
    check_eq("t5_newest_pc", pc, 32'h1c00_0400);

    // 6: reset while a redirect is pending discards it
    cycle(1'b0, 1'b0, 1'b1, 32'h1c00_0500);
    cycle(1'b1, 1'b0, 1'b0, 32'h0);
    check_eq("t6_reset_pc", pc, 32'h1bff_fffc);
    check_eq("t6_reset_valid", {31'd0, to_fs_valid}, 32'd0);
    check_eq("t6_reset_en", {31'd0, inst_sram_en}, 32'd0);
    cycle(1'b0, 1'b1, 1'b0, 32'h0);
    check_eq("t6_restart_pc", pc, 32'h1c00_0000);

    // target alignment and 32-bit wrap of the sequential PC
    cycle(1'b0, 1'b1, 1'b1, 32'hffff_ffff);
    check_eq("align_pc", pc, 32'hffff_fffc);
    cycle(1'b0, 1'b1, 1'b0, 32'h0);
    check_eq("wrap_pc", pc, 32'h0000_0000);

    // random traffic against the model
    for (int i = 0; i < 600; i++) begin
      cycle(($urandom_range(0, 99) == 0),
            ($urandom_range(0, 9) < 7),
            ($urandom_range(0, 5) == 0),
            $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
